// File: rtl/blink_arbiter.sv
// blink_arbiter: round-robin share of a single LED blink engine.
// Each granted requester gets a burst of N ON/OFF pulses followed by a
// quiet gap; completion is reported with a one-cycle done strobe.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// ON    | LED high for ON_CYC cycles of the current pulse
// OFF   | LED low for OFF_CYC cycles after a pulse
// GAP   | LED low for GAP_CYC cycles before releasing the engine
module blink_arbiter #(
    parameter int NREQ    = 4,
    parameter int CBITS   = 8,
    parameter int PBITS   = 3,
    parameter int ON_CYC  = 4,
    parameter int OFF_CYC = 4,
    parameter int GAP_CYC = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*PBITS-1:0]  pulses,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic                   led,
    output logic                   busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CBITS-1:0] ON_LOAD  = CBITS'(ON_CYC - 1);
    localparam logic [CBITS-1:0] OFF_LOAD = CBITS'(OFF_CYC - 1);
    localparam logic [CBITS-1:0] GAP_LOAD = CBITS'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CBITS-1:0]  timer;
    logic [CBITS-1:0]  timer_nxt;
    logic [PBITS-1:0]  rem;
    logic [PBITS-1:0]  rem_nxt;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     rr_ptr_nxt;
    logic [NREQ-1:0]   grant_nxt;
    logic [NREQ-1:0]   done_nxt;
    logic              led_nxt;

    logic [IW-1:0]     win;
    logic              win_vld;
    logic [IW-1:0]     idx;
    logic [PBITS-1:0]  win_pulses;

    // Round-robin pick: first pending requester after rr_ptr, wrapping.
    always_comb begin
        win     = rr_ptr;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    assign win_pulses = pulses[int'(win)*PBITS +: PBITS];

    // State and registered outputs; reset aborts any burst without a done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            timer  <= '0;
            rem    <= '0;
            rr_ptr <= IW'(NREQ - 1);
            grant  <= '0;
            done   <= '0;
            led    <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            rem    <= rem_nxt;
            rr_ptr <= rr_ptr_nxt;
            grant  <= grant_nxt;
            done   <= done_nxt;
            led    <= led_nxt;
        end
    end

    // Next state, phase timer, remaining pulse count and arbitration pointer.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        rem_nxt    = rem;
        rr_ptr_nxt = rr_ptr;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    rr_ptr_nxt = win;
                    rem_nxt    = win_pulses;
                    if (win_pulses != '0) begin
                        state_nxt = S_ON;
                        timer_nxt = ON_LOAD;
                    end else begin
                        state_nxt = S_GAP;
                        timer_nxt = GAP_LOAD;
                    end
                end
            end
            S_ON: begin
                if (timer == '0) begin
                    state_nxt = S_OFF;
                    timer_nxt = OFF_LOAD;
                    rem_nxt   = rem - PBITS'(1);
                end else begin
                    timer_nxt = timer - CBITS'(1);
                end
            end
            S_OFF: begin
                if (timer == '0) begin
                    if (rem != '0) begin
                        state_nxt = S_ON;
                        timer_nxt = ON_LOAD;
                    end else begin
                        state_nxt = S_GAP;
                        timer_nxt = GAP_LOAD;
                    end
                end else begin
                    timer_nxt = timer - CBITS'(1);
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    timer_nxt = timer - CBITS'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; done mirrors the released grant.
    always_comb begin
        led_nxt   = (state_nxt == S_ON);
        grant_nxt = grant;
        done_nxt  = '0;
        if (state == S_IDLE) begin
            grant_nxt = win_vld ? (NREQ'(1) << win) : '0;
        end else if (state == S_GAP && state_nxt == S_IDLE) begin
            grant_nxt = '0;
            done_nxt  = grant;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_blink_arbiter.sv
// tb_blink_arbiter: directed scenarios plus randomized traffic against a
// burst-level reference model. The model predicts every cycle's outputs from
// the burst start time and pulse count; a monitor compares outputs each cycle
// and pops a scoreboard entry at every done strobe.
module tb_blink_arbiter;
    localparam int NREQ    = 4;
    localparam int CBITS   = 8;
    localparam int PBITS   = 3;
    localparam int ON_CYC  = 2;
    localparam int OFF_CYC = 3;
    localparam int GAP_CYC = 4;
    localparam int PER     = ON_CYC + OFF_CYC;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*PBITS-1:0] pulses = '0;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  led;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    blink_arbiter #(
        .NREQ(NREQ), .CBITS(CBITS), .PBITS(PBITS),
        .ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .pulses(pulses),
        .grant(grant), .done(done), .led(led), .busy(busy)
    );

    typedef struct {
        int owner;
        int p;
    } burst_t;

    burst_t sb[$];

    function automatic bit bit_of(input logic [31:0] v, input int i);
        logic [4:0] s;
        s = i[4:0];
        return v[s];
    endfunction

    function automatic int pulse_of(input logic [31:0] pv, input int i);
        return int'((pv >> (i*PBITS)) & 32'((1 << PBITS) - 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each edge, decide arbitration and predict outputs.
    int              now = 0;
    bit              m_act = 1'b0;
    int              m_owner = 0;
    int              m_p = 0;
    int              m_start = 0;
    int              m_end = 0;
    int              m_ptr = NREQ - 1;
    logic [NREQ-1:0] exp_grant = '0;
    logic [NREQ-1:0] exp_done = '0;
    logic            exp_led = 1'b0;
    logic            exp_busy = 1'b0;

    always @(posedge clk) begin
        int     w;
        int     o;
        burst_t b;
        now++;
        if (rst) begin
            m_act = 1'b0;
            m_ptr = NREQ - 1;
            sb.delete();
            exp_grant = '0;
            exp_done  = '0;
            exp_led   = 1'b0;
            exp_busy  = 1'b0;
        end else begin
            if ((!m_act || now > m_end) && req != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (w < 0 && bit_of(32'(req), (m_ptr + k) % NREQ)) w = (m_ptr + k) % NREQ;
                m_act   = 1'b1;
                m_owner = w;
                m_p     = pulse_of(32'(pulses), w);
                m_start = now;
                m_end   = now + m_p*PER + GAP_CYC;
                m_ptr   = w;
                b.owner = w;
                b.p     = m_p;
                sb.push_back(b);
            end
            exp_grant = '0;
            exp_done  = '0;
            exp_led   = 1'b0;
            exp_busy  = 1'b0;
            if (m_act && now < m_end) begin
                o = now - m_start;
                exp_grant = NREQ'(1) << m_owner;
                exp_busy  = 1'b1;
                exp_led   = (o < m_p*PER) && ((o % PER) < ON_CYC);
            end else if (m_act && now == m_end) begin
                exp_done = NREQ'(1) << m_owner;
            end
        end
    end

    // Monitor: per-cycle output compare, liveness bound, scoreboard pop on done.
    int              led_cnt = 0;
    logic            led_prev = 1'b0;
    logic [NREQ-1:0] gprev = '0;
    int              waits[NREQ];

    initial begin
        burst_t b;
        foreach (waits[i]) waits[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                led_cnt  = 0;
                led_prev = 1'b0;
                gprev    = '0;
                foreach (waits[i]) waits[i] = 0;
            end else begin
                chk("grant", 32'(grant), 32'(exp_grant));
                chk("done", 32'(done), 32'(exp_done));
                chk("led", 32'(led), 32'(exp_led));
                chk("busy", 32'(busy), 32'(exp_busy));
                if (led && !led_prev) led_cnt++;
                led_prev = led;
                if (grant != '0 && gprev == '0) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (bit_of(32'(grant), i)) begin
                            waits[i] = 0;
                        end else if (bit_of(32'(req), i)) begin
                            waits[i]++;
                            checks++;
                            if (waits[i] > NREQ - 1) begin
                                failures++;
                                $display("FAIL liveness: req%0d lost %0d arbitrations, limit %0d", i, waits[i], NREQ - 1);
                            end
                        end else begin
                            waits[i] = 0;
                        end
                    end
                end
                gprev = grant;
                if (done != '0) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL sb_empty: got done %0h expected no done", done);
                    end else begin
                        b = sb.pop_front();
                        chk("done_owner", 32'(done), 32'(NREQ'(1) << b.owner));
                        chk("pulse_count", 32'(led_cnt), 32'(b.p));
                    end
                    led_cnt = 0;
                end
            end
        end
    end

    task automatic set_pulses(input int i, input int v);
        logic [31:0] pv;
        logic [31:0] mask;
        pv     = 32'(pulses);
        mask   = 32'((1 << PBITS) - 1) << (i*PBITS);
        pv     = (pv & ~mask) | ((32'(v) << (i*PBITS)) & mask);
        pulses = pv[NREQ*PBITS-1:0];
    endtask

    task automatic wait_done(input int i, input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk);
            #2;
            if (bit_of(32'(done), i)) seen = 1'b1;
        end
    endtask

    task automatic wait_grant_rise(input int budget, output logic [NREQ-1:0] g, output bit seen);
        logic [NREQ-1:0] gp;
        gp   = grant;
        g    = '0;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk);
            #2;
            if (grant != '0 && gp == '0) begin
                seen = 1'b1;
                g    = grant;
            end
            gp = grant;
        end
    endtask

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < budget && !idle; c++) begin
            @(posedge clk);
            #2;
            if (!busy && grant == '0) idle = 1'b1;
        end
        chk("idle_reached", 32'(idle), 32'(1));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        bit              ok;
        bit              got3;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] seq [5];
        int              t0;
        int              n;

        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_led", 32'(led), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;

        // Single request, two pulses; done lands 15 cycles after req is seen.
        set_pulses(0, 2);
        req = 4'b0001;
        t0  = now;
        wait_done(0, 100, ok);
        chk("t1_done_seen", 32'(ok), 32'(1));
        chk("t1_done_cycle", 32'(now - t0), 32'(15));
        req = '0;
        wait_idle(50);

        // Round-robin with every requester held.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_pulses(i, 1);
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant_rise(100, g, ok);
            chk("t2_grant_seen", 32'(ok), 32'(1));
            chk("t2_grant_order", 32'(g), 32'(seq[k]));
        end
        req = '0;
        wait_idle(100);

        // Zero pulses: only the gap runs.
        set_pulses(2, 0);
        req = 4'b0100;
        t0  = now;
        wait_done(2, 100, ok);
        chk("t3_done_seen", 32'(ok), 32'(1));
        chk("t3_done_cycle", 32'(now - t0), 32'(1 + GAP_CYC));
        req = '0;
        wait_idle(50);

        // Drop req and change pulses mid-burst; burst still completes with 3 pulses.
        set_pulses(1, 3);
        req = 4'b0010;
        wait_grant_rise(50, g, ok);
        chk("t4_grant_seen", 32'(ok), 32'(1));
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        req = '0;
        set_pulses(1, 5);
        wait_done(1, 100, ok);
        chk("t4_done_seen", 32'(ok), 32'(1));
        wait_idle(50);

        // Async reset while LED is on; pointer returns to its reset value.
        set_pulses(0, 3);
        req = 4'b0001;
        ok  = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(posedge clk);
            #2;
            if (led) ok = 1'b1;
        end
        chk("t5_led_on", 32'(ok), 32'(1));
        #3;
        rst = 1'b1;
        req = 4'b1000;
        #1;
        chk("t5_async_led", 32'(led), 32'(0));
        chk("t5_async_grant", 32'(grant), 32'(0));
        chk("t5_async_done", 32'(done), 32'(0));
        chk("t5_async_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("t5_grant_after_rst", 32'(grant), 32'(4'b1000));
        wait_done(3, 100, ok);
        chk("t5_done_seen", 32'(ok), 32'(1));
        req = '0;
        wait_idle(50);

        // Requester 0 keeps asking; requester 3 must win by the second arbitration.
        do_reset();
        set_pulses(0, 1);
        set_pulses(3, 1);
        req  = 4'b1001;
        n    = 0;
        got3 = 1'b0;
        for (int k = 0; k < 4 && !got3; k++) begin
            wait_grant_rise(100, g, ok);
            n++;
            if (g[3]) got3 = 1'b1;
        end
        chk("t6_req3_by_second", 32'(got3 && n <= 2), 32'(1));
        req = '0;
        wait_idle(100);

        // Randomized traffic: random raises, pulse counts, mid-burst drops, held reqs.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (bit_of(32'(done), i)) begin
                    if ($urandom_range(3) != 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(3) == 0) begin
                        set_pulses(i, int'($urandom_range(7)));
                        req[i] = 1'b1;
                    end
                end else if (grant[i] && $urandom_range(15) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(9) == 0) set_pulses(i, int'($urandom_range(7)));
            end
        end
        req = '0;
        wait_idle(100);
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
